nonce_scan_ctrl: RTL and testbench

NONCE_SCAN_CTRL -- requirements
Module: nonce_scan_ctrl

---
 rtl/sha_miner_pkg.sv | 22 ++
 rtl/nonce_scan_ctrl_if.sv | 37 +++
 rtl/nonce_result_fifo.sv | 53 +++++
 rtl/nonce_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_nonce_scan_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_miner_pkg.sv
// Shared types and constants for the nonce scan controller.
// Holds the scan FSM encoding and hash-pipeline defaults.
package sha_miner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } scan_state_t;

   localparam int HASH_W       = 256;
   localparam int PIPE_LAT_DEF = 130;

   // Unsigned compare of a lane digest against the difficulty target.
   function automatic logic lane_hit(
      input logic [HASH_W-1:0] hash,
      input logic [HASH_W-1:0] target
   );
      return hash <= target;
   endfunction

endpackage

// File: rtl/nonce_scan_ctrl_if.sv
// Issue, hash-return and result buses of the nonce scan controller.
// master = controller side, slave = hash pipeline / result consumer.
interface nonce_scan_ctrl_if #(
   parameter int LANES   = 1,
   parameter int NONCE_W = 32,
   parameter int TIME_W  = 32
);
   import sha_miner_pkg::*;

   logic                      issue_valid;
   logic [LANES-1:0]          issue_mask;
   logic [LANES*NONCE_W-1:0]  issue_nonce;
   logic [TIME_W-1:0]         issue_time;

   logic                      hash_valid;
   logic [LANES*HASH_W-1:0]   hash_in;

   logic                      res_valid;
   logic                      res_ready;
   logic [NONCE_W-1:0]        res_nonce;
   logic [TIME_W-1:0]         res_time;

   modport master (
      output issue_valid, issue_mask, issue_nonce, issue_time,
      input  hash_valid, hash_in,
      output res_valid, res_nonce, res_time,
      input  res_ready
   );

   modport slave (
      input  issue_valid, issue_mask, issue_nonce, issue_time,
      output hash_valid, hash_in,
      input  res_valid, res_nonce, res_time,
      output res_ready
   );

endinterface

// File: rtl/nonce_result_fifo.sv
// Small result FIFO of {nonce, time} entries with valid/ready pop.
// Pushes while full are dropped; the caller flags the overflow.
module nonce_result_fifo #(
   parameter int DEPTH   = 4,
   parameter int NONCE_W = 32,
   parameter int TIME_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [NONCE_W-1:0] push_nonce,
   input  logic [TIME_W-1:0]  push_time,
   output logic               full,
   output logic               pop_valid,
   input  logic               pop_ready,
   output logic [NONCE_W-1:0] pop_nonce,
   output logic [TIME_W-1:0]  pop_time
);

   localparam int AW = $clog2(DEPTH);

   logic [NONCE_W+TIME_W-1:0] mem [DEPTH];
   logic [AW:0]               wp;
   logic [AW:0]               rp;
   logic                      empty;
   logic                      wr;
   logic                      rd;

   assign empty     = (wp == rp);
   assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign wr        = push && !full;
   assign rd        = !empty && pop_ready;
   assign pop_valid = !empty;

   assign {pop_nonce, pop_time} = empty ? '0 : mem[rp[AW-1:0]];

   // Read/write pointers; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible behind the pointers.
   always_ff @(posedge clk) begin
      if (wr) mem[wp[AW-1:0]] <= {push_nonce, push_time};
   end

endmodule

// File: rtl/nonce_scan_ctrl.sv
// Nonce range scanner feeding a fixed-latency double-SHA pipeline.
// Tags each issue, matches returning hashes and queues winning nonces.
module nonce_scan_ctrl
   import sha_miner_pkg::*;
#(
   parameter int LANES     = 1,
   parameter int NONCE_W   = 32,
   parameter int TIME_W    = 32,
   parameter int PIPE_LAT  = PIPE_LAT_DEF,
   parameter int RES_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [NONCE_W-1:0] nonce_end,
   input  logic [TIME_W-1:0]  time_in,
   input  logic [HASH_W-1:0]  target_in,
   input  logic               continue_mode,
   input  logic               time_roll,
   nonce_scan_ctrl_if.master  bus,
   output logic               busy,
   output logic               done,
   output logic               exhausted,
   output logic               res_overflow,
   output logic               err_align
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW = $clog2(PIPE_LAT + 1);
   localparam int RW = NONCE_W + 1;

   scan_state_t state;
   scan_state_t state_nx;

   logic [NONCE_W-1:0]       base;
   logic [NONCE_W-1:0]       lo;
   logic [RW-1:0]            remaining;
   logic [RW-1:0]            reload;
   logic [RW-1:0]            size;
   logic [TIME_W-1:0]        cur_time;
   logic [HASH_W-1:0]        target;
   logic                     cont_mode;
   logic                     roll;
   logic                     found;
   logic [CW-1:0]            inflight;

   logic                     scanning;
   logic                     last_issue;
   logic [LANES-1:0]         mask;
   logic [LANES*NONCE_W-1:0] nonce_vec;

   logic                     tag_v [PIPE_LAT];
   logic [LANES-1:0]         tag_m [PIPE_LAT];
   logic [NONCE_W-1:0]       tag_b [PIPE_LAT];
   logic [TIME_W-1:0]        tag_t [PIPE_LAT];

   logic                     out_v;
   logic [LANES-1:0]         out_m;
   logic [NONCE_W-1:0]       out_b;
   logic [TIME_W-1:0]        out_t;

   logic [LANES-1:0]         hit;
   logic [LW-1:0]            sel;
   logic                     any;
   logic                     multi;
   logic                     push;
   logic                     stop_hit;
   logic                     fifo_full;
   logic [NONCE_W-1:0]       wr_nonce;

   logic                     f_valid;
   logic [NONCE_W-1:0]       f_nonce;
   logic [TIME_W-1:0]        f_time;

   assign scanning   = (state == ST_SCAN);
   assign last_issue = remaining <= RW'(LANES);
   assign size       = {1'b0, nonce_end - nonce_start} + RW'(1);
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DRAIN) && (inflight == '0);

   assign out_v = tag_v[PIPE_LAT-1];
   assign out_m = tag_m[PIPE_LAT-1];
   assign out_b = tag_b[PIPE_LAT-1];
   assign out_t = tag_t[PIPE_LAT-1];

   assign bus.issue_valid = scanning;
   assign bus.issue_mask  = mask;
   assign bus.issue_nonce = nonce_vec;
   assign bus.issue_time  = scanning ? cur_time : '0;
   assign bus.res_valid   = f_valid;
   assign bus.res_nonce   = f_nonce;
   assign bus.res_time    = f_time;

   // Lane nonces and the tail mask for a partial final issue.
   always_comb begin
      mask      = '0;
      nonce_vec = '0;
      for (int i = 0; i < LANES; i++) begin
         if (scanning) begin
            mask[i] = RW'(i) < remaining;
            nonce_vec[i*NONCE_W +: NONCE_W] = base + NONCE_W'(i);
         end
      end
   end

   // Hit detection on the delay-line output; lowest lane wins.
   always_comb begin
      hit = '0;
      sel = '0;
      any = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         hit[i] = out_v && bus.hash_valid && out_m[i] &&
                  lane_hit(bus.hash_in[i*HASH_W +: HASH_W], target);
      end
      if (found) hit = '0;
      for (int i = 0; i < LANES; i++) begin
         if (hit[i] && !any) begin
            sel = LW'(i);
            any = 1'b1;
         end
      end
   end

   assign multi    = |(hit & (hit - LANES'(1)));
   assign push     = any && !fifo_full;
   assign stop_hit = push && !cont_mode;
   assign wr_nonce = out_b + NONCE_W'(sel);

   // Scan FSM next state.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:
            if (start) state_nx = ST_SCAN;
         ST_SCAN:
            if (stop || stop_hit || (last_issue && !roll))
               state_nx = ST_DRAIN;
         ST_DRAIN:
            if (inflight == '0) state_nx = ST_IDLE;
         default:
            state_nx = ST_IDLE;
      endcase
   end

   // Scan FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Tag valid bits and the in-flight count; reset drops every tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_LAT; i++) tag_v[i] <= 1'b0;
         inflight <= '0;
      end else begin
         tag_v[0] <= scanning;
         for (int i = 1; i < PIPE_LAT; i++) tag_v[i] <= tag_v[i-1];
         inflight <= inflight + CW'(scanning) - CW'(out_v);
      end
   end

   // Tag payload; qualified by the valid bits so it carries no reset.
   always_ff @(posedge clk) begin
      tag_m[0] <= mask;
      tag_b[0] <= base;
      tag_t[0] <= cur_time;
      for (int i = 1; i < PIPE_LAT; i++) begin
         tag_m[i] <= tag_m[i-1];
         tag_b[i] <= tag_b[i-1];
         tag_t[i] <= tag_t[i-1];
      end
   end

   // Scan context, range walk, time roll and sticky status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base         <= '0;
         lo           <= '0;
         remaining    <= '0;
         reload       <= '0;
         cur_time     <= '0;
         target       <= '0;
         cont_mode    <= 1'b0;
         roll         <= 1'b0;
         found        <= 1'b0;
         exhausted    <= 1'b0;
         res_overflow <= 1'b0;
         err_align    <= 1'b0;
      end else begin
         if (bus.hash_valid != out_v) err_align <= 1'b1;
         if (any && (multi || fifo_full)) res_overflow <= 1'b1;
         if (stop_hit) found <= 1'b1;
         if (scanning) begin
            if (!last_issue) begin
               base      <= base + NONCE_W'(LANES);
               remaining <= remaining - RW'(LANES);
            end else if (!stop && roll) begin
               cur_time  <= cur_time + 1'b1;
               base      <= lo;
               remaining <= reload;
            end else if (!stop) begin
               exhausted <= 1'b1;
            end
         end
         if (state == ST_IDLE && start) begin
            lo           <= nonce_start;
            base         <= nonce_start;
            remaining    <= size;
            reload       <= size;
            cur_time     <= time_in;
            target       <= target_in;
            cont_mode    <= continue_mode;
            roll         <= time_roll;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            res_overflow <= 1'b0;
            err_align    <= 1'b0;
         end
      end
   end

   nonce_result_fifo #(
      .DEPTH   (RES_DEPTH),
      .NONCE_W (NONCE_W),
      .TIME_W  (TIME_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_nonce (wr_nonce),
      .push_time  (out_t),
      .full       (fifo_full),
      .pop_valid  (f_valid),
      .pop_ready  (bus.res_ready),
      .pop_nonce  (f_nonce),
      .pop_time   (f_time)
   );

endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// Bench for nonce_scan_ctrl: one 1-lane and one 4-lane instance,
// each fed by a fixed-latency hash pipeline model and a result scoreboard.
module tb_nonce_scan_ctrl;
   import sha_miner_pkg::*;

   localparam int PL = PIPE_LAT_DEF;
   localparam int NW = 32;
   localparam int TW = 32;

   typedef struct packed {
      logic [NW-1:0] n;
      logic [TW-1:0] t;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_start = 1'b0;
   logic          b_start = 1'b0;
   logic          stop = 1'b0;
   logic [NW-1:0] n_lo = '0;
   logic [NW-1:0] n_hi = '0;
   logic [TW-1:0] t_in = '0;
   logic [255:0]  tgt = '0;
   logic          cont = 1'b1;
   logic          roll = 1'b0;

   logic a_busy, a_done, a_exh, a_ovf, a_err;
   logic b_busy, b_done, b_exh, b_ovf, b_err;

   logic          a_drop_en = 1'b0;
   logic [NW-1:0] a_drop_n = '0;
   logic          a_sel = 1'b0;

   int   n_tests = 0;
   int   n_fail = 0;
   res_t a_q[$];
   res_t b_q[$];
   res_t a_e;
   res_t b_e;

   nonce_scan_ctrl_if #(.LANES(1), .NONCE_W(NW), .TIME_W(TW)) ia();
   nonce_scan_ctrl_if #(.LANES(4), .NONCE_W(NW), .TIME_W(TW)) ib();

   nonce_scan_ctrl #(
      .LANES(1), .NONCE_W(NW), .TIME_W(TW), .PIPE_LAT(PL), .RES_DEPTH(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .stop(stop),
      .nonce_start(n_lo), .nonce_end(n_hi), .time_in(t_in),
      .target_in(tgt), .continue_mode(cont), .time_roll(roll),
      .bus(ia.master), .busy(a_busy), .done(a_done),
      .exhausted(a_exh), .res_overflow(a_ovf), .err_align(a_err)
   );

   nonce_scan_ctrl #(
      .LANES(4), .NONCE_W(NW), .TIME_W(TW), .PIPE_LAT(PL), .RES_DEPTH(4)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .stop(stop),
      .nonce_start(n_lo), .nonce_end(n_hi), .time_in(t_in),
      .target_in(tgt), .continue_mode(cont), .time_roll(roll),
      .bus(ib.master), .busy(b_busy), .done(b_done),
      .exhausted(b_exh), .res_overflow(b_ovf), .err_align(b_err)
   );

   // External pipeline model for the 1-lane instance.
   logic          av [PL];
   logic [NW-1:0] an [PL];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PL; i++) av[i] <= 1'b0;
      end else begin
         av[0] <= ia.issue_valid;
         an[0] <= ia.issue_nonce;
         for (int i = 1; i < PL; i++) begin
            av[i] <= av[i-1];
            an[i] <= an[i-1];
         end
      end
   end
   assign ia.hash_valid = av[PL-1] && !(a_drop_en && an[PL-1] == a_drop_n);
   assign ia.hash_in = (a_sel && an[PL-1] != 32'd5 && an[PL-1] != 32'd7)
                       ? {256{1'b1}} : '0;

   // External pipeline model for the 4-lane instance: every lane hits.
   logic bv [PL];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PL; i++) bv[i] <= 1'b0;
      end else begin
         bv[0] <= ib.issue_valid;
         for (int i = 1; i < PL; i++) bv[i] <= bv[i-1];
      end
   end
   assign ib.hash_valid = bv[PL-1];
   assign ib.hash_in    = '0;

   // Scoreboard pop for the 1-lane instance.
   always @(negedge clk) begin
      if (ia.res_valid && ia.res_ready) begin
         n_tests++;
         if (a_q.size() == 0) begin
            n_fail++;
            $display("FAIL a_result_extra got n=%h t=%h want none",
                     ia.res_nonce, ia.res_time);
         end else begin
            a_e = a_q.pop_front();
            if (ia.res_nonce !== a_e.n || ia.res_time !== a_e.t) begin
               n_fail++;
               $display("FAIL a_result got n=%h t=%h want n=%h t=%h",
                        ia.res_nonce, ia.res_time, a_e.n, a_e.t);
            end
         end
      end
   end

   // Scoreboard pop for the 4-lane instance.
   always @(negedge clk) begin
      if (ib.res_valid && ib.res_ready) begin
         n_tests++;
         if (b_q.size() == 0) begin
            n_fail++;
            $display("FAIL b_result_extra got n=%h t=%h want none",
                     ib.res_nonce, ib.res_time);
         end else begin
            b_e = b_q.pop_front();
            if (ib.res_nonce !== b_e.n || ib.res_time !== b_e.t) begin
               n_fail++;
               $display("FAIL b_result got n=%h t=%h want n=%h t=%h",
                        ib.res_nonce, ib.res_time, b_e.n, b_e.t);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit on_b, input int budget,
                            output int cyc);
      cyc = 0;
      while (!(on_b ? b_done : a_done) && cyc < budget) begin
         tick();
         cyc++;
      end
      n_tests++;
      if (cyc >= budget) begin
         n_fail++;
         $display("FAIL done_timeout got no done after %0d want done", cyc);
      end
   endtask

   task automatic test_reset();
      tick(2);
      n_tests++;
      if ({a_busy, a_done, a_exh, a_ovf, a_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_a_status got %b want 00000",
                  {a_busy, a_done, a_exh, a_ovf, a_err});
      end
      n_tests++;
      if ({b_busy, b_done, b_exh, b_ovf, b_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_b_status got %b want 00000",
                  {b_busy, b_done, b_exh, b_ovf, b_err});
      end
      n_tests++;
      if ({ia.issue_valid, ia.res_valid, ib.issue_valid, ib.res_valid,
           ib.issue_mask} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_bus got %b%b%b%b %b want 0",
                  ia.issue_valid, ia.res_valid, ib.issue_valid,
                  ib.res_valid, ib.issue_mask);
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_linear();
      int cyc;
      n_lo = 32'd0; n_hi = 32'd9; t_in = 32'h1234;
      tgt = '1; cont = 1'b1; roll = 1'b0; ia.res_ready = 1'b1;
      for (int k = 0; k < 10; k++) a_q.push_back({32'(k), 32'h1234});
      a_start = 1'b1; tick(); a_start = 1'b0;
      n_tests++;
      if (a_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL linear_busy got %b want 1", a_busy);
      end
      wait_done(1'b0, 400, cyc);
      n_tests++;
      if (cyc != PL + 10) begin
         n_fail++;
         $display("FAIL linear_done_latency got %0d want %0d", cyc, PL + 10);
      end
      n_tests++;
      if (a_exh !== 1'b1) begin
         n_fail++;
         $display("FAIL linear_exhausted got %b want 1", a_exh);
      end
      tick();
      n_tests++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL linear_idle got done=%b busy=%b want 0 0",
                  a_done, a_busy);
      end
      tick(4);
      n_tests++;
      if (a_q.size() != 0) begin
         n_fail++;
         $display("FAIL linear_results got %0d left want 0", a_q.size());
      end
   endtask

   task automatic test_overflow();
      int cyc;
      ia.res_ready = 1'b0;
      n_lo = 32'd0; n_hi = 32'd6; t_in = 32'h77;
      tgt = '1; cont = 1'b1; roll = 1'b0;
      a_drop_en = 1'b1; a_drop_n = 32'd3;
      a_q.push_back({32'd0, 32'h77});
      a_q.push_back({32'd1, 32'h77});
      a_q.push_back({32'd2, 32'h77});
      a_q.push_back({32'd4, 32'h77});
      a_start = 1'b1; tick(); a_start = 1'b0;
      wait_done(1'b0, 400, cyc);
      n_tests++;
      if ({a_ovf, a_err, a_exh} !== 3'b111) begin
         n_fail++;
         $display("FAIL ovf_flags got ovf=%b err=%b exh=%b want 1 1 1",
                  a_ovf, a_err, a_exh);
      end
      tick(3);
      n_tests++;
      if (ia.res_valid !== 1'b1 || ia.res_nonce !== 32'd0 ||
          ia.res_time !== 32'h77) begin
         n_fail++;
         $display("FAIL ovf_hold got v=%b n=%h t=%h want 1 0 77",
                  ia.res_valid, ia.res_nonce, ia.res_time);
      end
      a_drop_en = 1'b0;
      ia.res_ready = 1'b1;
      tick(6);
      n_tests++;
      if (a_q.size() != 0 || ia.res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_drain got %0d left v=%b want 0 0",
                  a_q.size(), ia.res_valid);
      end
   endtask

   task automatic test_wrap();
      int cyc;
      ib.res_ready = 1'b1;
      n_lo = 32'hFFFF_FFFE; n_hi = 32'd3; t_in = 32'h55;
      tgt = '1; cont = 1'b1; roll = 1'b0;
      b_q.push_back({32'hFFFF_FFFE, 32'h55});
      b_q.push_back({32'd2, 32'h55});
      b_start = 1'b1; tick(); b_start = 1'b0;
      n_tests++;
      if (ib.issue_valid !== 1'b1 || ib.issue_mask !== 4'b1111 ||
          ib.issue_nonce !== {32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE} ||
          ib.issue_time !== 32'h55) begin
         n_fail++;
         $display("FAIL wrap_issue1 got v=%b m=%b n=%h t=%h",
                  ib.issue_valid, ib.issue_mask, ib.issue_nonce,
                  ib.issue_time);
      end
      tick();
      n_tests++;
      if (ib.issue_valid !== 1'b1 || ib.issue_mask !== 4'b0011 ||
          ib.issue_nonce[63:0] !== {32'd3, 32'd2}) begin
         n_fail++;
         $display("FAIL wrap_issue2 got v=%b m=%b n=%h want 1 0011 3,2",
                  ib.issue_valid, ib.issue_mask, ib.issue_nonce[63:0]);
      end
      tick();
      n_tests++;
      if (ib.issue_valid !== 1'b0 || b_exh !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_end got v=%b exh=%b want 0 1",
                  ib.issue_valid, b_exh);
      end
      wait_done(1'b1, 400, cyc);
      n_tests++;
      if (b_ovf !== 1'b1 || b_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_flags got ovf=%b err=%b want 1 0", b_ovf, b_err);
      end
      tick(4);
      n_tests++;
      if (b_q.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_results got %0d left want 0", b_q.size());
      end
   endtask

   task automatic test_first_hit();
      int cyc;
      ia.res_ready = 1'b1;
      n_lo = 32'd0; n_hi = 32'd999; t_in = 32'd9;
      tgt = 256'd1; cont = 1'b0; roll = 1'b0; a_sel = 1'b1;
      a_q.push_back({32'd5, 32'd9});
      a_start = 1'b1; tick(); a_start = 1'b0;
      n_tests++;
      if (a_err !== 1'b0 || a_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL first_clear got err=%b ovf=%b want 0 0", a_err, a_ovf);
      end
      wait_done(1'b0, 1000, cyc);
      n_tests++;
      if (a_exh !== 1'b0) begin
         n_fail++;
         $display("FAIL first_exhausted got %b want 0", a_exh);
      end
      tick(4);
      n_tests++;
      if (a_q.size() != 0) begin
         n_fail++;
         $display("FAIL first_results got %0d left want 0", a_q.size());
      end
      a_sel = 1'b0; cont = 1'b1;
   endtask

   task automatic test_time_roll();
      int cyc;
      logic [NW-1:0] en;
      logic [TW-1:0] et;
      ia.res_ready = 1'b1;
      n_lo = 32'd0; n_hi = 32'd3; t_in = 32'hFFFF_FFFF;
      tgt = '1; cont = 1'b1; roll = 1'b1;
      a_start = 1'b1; tick(); a_start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         en = 32'(k % 4);
         et = 32'hFFFF_FFFF + 32'(k / 4);
         n_tests++;
         if (ia.issue_valid !== 1'b1 || ia.issue_nonce !== en ||
             ia.issue_time !== et) begin
            n_fail++;
            $display("FAIL roll_issue%0d got v=%b n=%h t=%h want 1 %h %h",
                     k, ia.issue_valid, ia.issue_nonce, ia.issue_time,
                     en, et);
         end
         a_q.push_back({en, et});
         if (k == 8) stop = 1'b1;
         tick();
      end
      stop = 1'b0;
      n_tests++;
      if (ia.issue_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL roll_stop got v=%b want 0", ia.issue_valid);
      end
      wait_done(1'b0, 400, cyc);
      n_tests++;
      if (a_exh !== 1'b0) begin
         n_fail++;
         $display("FAIL roll_exhausted got %b want 0", a_exh);
      end
      tick(4);
      n_tests++;
      if (a_q.size() != 0) begin
         n_fail++;
         $display("FAIL roll_results got %0d left want 0", a_q.size());
      end
      roll = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen;
      ia.res_ready = 1'b0;
      n_lo = 32'd0; n_hi = 32'd999; t_in = 32'd1;
      tgt = '1; cont = 1'b1; roll = 1'b0;
      a_start = 1'b1; tick(); a_start = 1'b0;
      tick(PL + 5);
      n_tests++;
      if (ia.res_valid !== 1'b1 || a_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pre got v=%b busy=%b want 1 1",
                  ia.res_valid, a_busy);
      end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if ({a_busy, a_done, a_exh, ia.issue_valid, ia.res_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid_out got %b want 00000",
                  {a_busy, a_done, a_exh, ia.issue_valid, ia.res_valid});
      end
      tick();
      rst_n = 1'b1;
      ia.res_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < PL + 20; k++) begin
         tick();
         if (a_done || a_busy || ia.res_valid) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_quiet got activity=%b want 0", seen);
      end
   endtask

   initial begin
      ia.res_ready = 1'b1;
      ib.res_ready = 1'b1;
      test_reset();
      test_linear();
      test_overflow();
      test_wrap();
      test_first_hit();
      test_time_roll();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
